// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: sigma constants, the quarter round, state word
// accessors and the legal round-count check.
package chacha_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_OUT
    } state_t;

    function automatic bit legal_rounds(input int rounds);
        return (rounds == 8) || (rounds == 12) || (rounds == 20);
    endfunction

    // Returns {a,b,c,d} after one quarter round.
    function automatic logic [127:0] quarterround(input logic [31:0] a_in, input logic [31:0] b_in,
                                                  input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Word 0 lives in the most significant 32 bits of the 512-bit state.
    function automatic logic [31:0] get_word(input logic [511:0] s, input int unsigned idx);
        return s[511 - 32*idx -: 32];
    endfunction

    function automatic logic [511:0] set_word(input logic [511:0] s, input int unsigned idx,
                                              input logic [31:0] w);
        logic [511:0] r;
        r = s;
        r[511 - 32*idx -: 32] = w;
        return r;
    endfunction

    function automatic logic [511:0] init_state(input logic [255:0] key, input logic [95:0] nonce,
                                                input logic [31:0] ctr);
        return {SIGMA0, SIGMA1, SIGMA2, SIGMA3, key, ctr, nonce};
    endfunction

    function automatic logic [511:0] add_states(input logic [511:0] x, input logic [511:0] y);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[511 - 32*i -: 32] = x[511 - 32*i -: 32] + y[511 - 32*i -: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha_keystream_core_double_round.sv
// Combinational ChaCha double round: four column quarter rounds followed by
// four diagonal quarter rounds.
module chacha_double_round
    import chacha_pkg::*;
(
    input  logic [511:0] state_in,
    output logic [511:0] state_out
);

    logic [31:0] w [16];
    logic [31:0] col [16];
    logic [31:0] diag [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_words
            assign w[gi] = state_in[511 - 32*gi -: 32];
            assign state_out[511 - 32*gi -: 32] = diag[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [127:0] q;
            assign q = quarterround(w[gi], w[gi+4], w[gi+8], w[gi+12]);
            assign col[gi]    = q[127:96];
            assign col[gi+4]  = q[95:64];
            assign col[gi+8]  = q[63:32];
            assign col[gi+12] = q[31:0];
        end

        // Diagonal gi touches (gi, 4+(gi+1)%4, 8+(gi+2)%4, 12+(gi+3)%4).
        for (gi = 0; gi < 4; gi++) begin : g_diag
            localparam int IB = 4 + ((gi + 1) % 4);
            localparam int IC = 8 + ((gi + 2) % 4);
            localparam int ID = 12 + ((gi + 3) % 4);
            logic [127:0] q;
            assign q = quarterround(col[gi], col[IB], col[IC], col[ID]);
            assign diag[gi] = q[127:96];
            assign diag[IB] = q[95:64];
            assign diag[IC] = q[63:32];
            assign diag[ID] = q[31:0];
        end
    endgenerate

endmodule

// File: rtl/chacha_keystream_core.sv
// Iterative ChaCha keystream generator: accepts a key/nonce/counter request and
// emits NBLK consecutive 512-bit blocks, advancing the block counter between them.
module chacha_keystream_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS       = 20,
    parameter int DR_PER_CYCLE = 1,
    parameter int NBLK_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [255:0]      in_key,
    input  logic [95:0]       in_nonce,
    input  logic [31:0]       in_ctr,
    input  logic [NBLK_W-1:0] in_nblk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      out_data,
    output logic              out_last,
    output logic              out_ctr_wrap
);

    localparam int DR_SAFE = (DR_PER_CYCLE < 1) ? 1 : DR_PER_CYCLE;
    localparam int N       = ROUNDS / (2 * DR_SAFE);
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [NBLK_W-1:0] ONE_BLK = NBLK_W'(1);

    generate
        if (!legal_rounds(ROUNDS)) begin : g_bad_rounds
            $error("chacha_keystream_core: ROUNDS must be 8, 12 or 20");
        end
        if (DR_PER_CYCLE < 1 || ((ROUNDS / 2) % DR_SAFE) != 0) begin : g_bad_dr
            $error("chacha_keystream_core: DR_PER_CYCLE must divide ROUNDS/2");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [511:0]      base_reg, work_reg, out_data_reg;
    logic [NBLK_W-1:0] remaining_reg;
    logic [CNT_W-1:0]  round_cnt_reg;
    logic              wrap_reg, out_last_reg, out_ctr_wrap_reg;
    logic [511:0]      chain [DR_PER_CYCLE+1];
    logic [511:0]      next_base;
    logic [511:0]      start_state;

    assign chain[0] = work_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DR_PER_CYCLE; gi++) begin : g_dr
            chacha_double_round u_dr (
                .state_in  (chain[gi]),
                .state_out (chain[gi+1])
            );
        end
    endgenerate

    assign start_state = init_state(in_key, in_nonce, in_ctr);
    assign next_base   = set_word(base_reg, 12, get_word(base_reg, 12) + 32'd1);

    assign in_ready     = (state_reg == ST_IDLE);
    assign out_valid    = (state_reg == ST_OUT);
    assign out_data     = out_data_reg;
    assign out_last     = out_last_reg;
    assign out_ctr_wrap = out_ctr_wrap_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (in_valid) state_next = ST_ROUND;
            ST_ROUND: if (round_cnt_reg == LAST_CNT) state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = (remaining_reg != ONE_BLK) ? ST_ROUND : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg         <= '0;
            work_reg         <= '0;
            out_data_reg     <= '0;
            remaining_reg    <= '0;
            round_cnt_reg    <= '0;
            wrap_reg         <= 1'b0;
            out_last_reg     <= 1'b0;
            out_ctr_wrap_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    base_reg      <= start_state;
                    work_reg      <= start_state;
                    remaining_reg <= (in_nblk == '0) ? ONE_BLK : in_nblk;
                    wrap_reg      <= 1'b0;
                    round_cnt_reg <= '0;
                end
                ST_ROUND: begin
                    work_reg <= chain[DR_PER_CYCLE];
                    if (round_cnt_reg == LAST_CNT) begin
                        out_data_reg     <= add_states(chain[DR_PER_CYCLE], base_reg);
                        out_last_reg     <= (remaining_reg == ONE_BLK);
                        out_ctr_wrap_reg <= wrap_reg;
                        round_cnt_reg    <= '0;
                    end else begin
                        round_cnt_reg <= round_cnt_reg + 1'b1;
                    end
                end
                ST_OUT: if (out_ready && remaining_reg != ONE_BLK) begin
                    // Next block restarts from the base state with counter + 1.
                    remaining_reg <= remaining_reg - ONE_BLK;
                    base_reg      <= next_base;
                    work_reg      <= next_base;
                    wrap_reg      <= (get_word(base_reg, 12) == 32'hFFFF_FFFF);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_keystream_core.sv
// Self-checking bench for chacha_keystream_core against a word-array ChaCha
// reference model, including a sweep over round/unroll configurations.
module tb_chacha_keystream_core;

    localparam int NBLK_W = 8;
    localparam int NSW = 5;
    localparam int SW_R [NSW] = '{8, 8, 12, 12, 20};
    localparam int SW_D [NSW] = '{1, 2, 1, 3, 2};
    localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                                 '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    localparam logic [255:0] RFC_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    localparam logic [95:0] RFC_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [255:0]      in_key = '0;
    logic [95:0]       in_nonce = '0;
    logic [31:0]       in_ctr = '0;
    logic [NBLK_W-1:0] in_nblk = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [511:0]      out_data;
    logic              out_last;
    logic              out_ctr_wrap;

    logic              sw_in_valid = 1'b0;
    logic [255:0]      sw_key = '0;
    logic [95:0]       sw_nonce = '0;
    logic [31:0]       sw_ctr = '0;
    logic [NSW-1:0]    sw_in_ready, sw_out_valid, sw_out_last, sw_out_wrap;
    logic [511:0]      sw_out_data [NSW];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    chacha_keystream_core #(.ROUNDS(20), .DR_PER_CYCLE(1), .NBLK_W(NBLK_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_nonce(in_nonce), .in_ctr(in_ctr), .in_nblk(in_nblk),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_ctr_wrap(out_ctr_wrap)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NSW; gi++) begin : g_sweep
            chacha_keystream_core #(.ROUNDS(SW_R[gi]), .DR_PER_CYCLE(SW_D[gi]), .NBLK_W(NBLK_W)) u_sw (
                .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[gi]),
                .in_key(sw_key), .in_nonce(sw_nonce), .in_ctr(sw_ctr), .in_nblk(8'd1),
                .out_valid(sw_out_valid[gi]), .out_ready(1'b1), .out_data(sw_out_data[gi]),
                .out_last(sw_out_last[gi]), .out_ctr_wrap(sw_out_wrap[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                               input logic [31:0] ctr, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = key[255 - 32*i -: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = nonce[95 - 32*i -: 32];
        x = s;
        for (int rr = 0; rr < rounds / 2; rr++) begin
            for (int q = 0; q < 8; q++) begin : qr
                int a, b, c, d;
                a = QI[q][0]; b = QI[q][1]; c = QI[q][2]; d = QI[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = x[i] + s[i];
        return r;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [255:0] key, input logic [95:0] nonce,
                            input logic [31:0] ctr, input logic [NBLK_W-1:0] nblk);
        in_key = key; in_nonce = nonce; in_ctr = ctr; in_nblk = nblk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles until out_valid is seen; -1 when the bound expires.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!out_valid && cyc < 200);
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 512'd0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else pass_cnt++;
        total_cnt++; if (out_ctr_wrap !== 1'b0) $display("FAIL reset_out_ctr_wrap got %b want 0", out_ctr_wrap); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rfc_vector();
        int cyc;
        logic [511:0] exp;
        exp = ref_block(RFC_KEY, RFC_NONCE, 32'd1, 20);
        out_ready = 1'b0;
        send_req(RFC_KEY, RFC_NONCE, 32'd1, 8'd1);
        wait_valid(cyc);
        $display("rfc block ctr=1 latency=%0d word0=%h", cyc, out_data[511:480]);
        total_cnt++; if (cyc != 10) $display("FAIL rfc_latency got %0d want 10", cyc); else pass_cnt++;
        total_cnt++; if (out_data[511:480] !== 32'he4e7f110) $display("FAIL rfc_word0 got %h want e4e7f110", out_data[511:480]); else pass_cnt++;
        total_cnt++; if (out_data[479:448] !== 32'h15593bd1) $display("FAIL rfc_word1 got %h want 15593bd1", out_data[479:448]); else pass_cnt++;
        total_cnt++; if (out_data[31:0] !== 32'h4e3c50a2) $display("FAIL rfc_word15 got %h want 4e3c50a2", out_data[31:0]); else pass_cnt++;
        total_cnt++; if (out_data !== exp) $display("FAIL rfc_block got %h want %h", out_data, exp); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b1) $display("FAIL rfc_last got %b want 1", out_last); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rfc_ready_busy got %b want 0", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rfc_return_idle got ready=%b valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_multi_block();
        int cyc;
        logic [511:0] exp;
        out_ready = 1'b1;
        send_req(RFC_KEY, RFC_NONCE, 32'd1, 8'd3);
        for (int b = 0; b < 3; b++) begin
            wait_valid(cyc);
            exp = ref_block(RFC_KEY, RFC_NONCE, 32'd1 + 32'(b), 20);
            $display("multi block %0d ctr=%0d gap=%0d last=%b", b, 1 + b, cyc, out_last);
            total_cnt++; if (cyc != ((b == 0) ? 10 : 11)) $display("FAIL multi_gap%0d got %0d want %0d", b, cyc, (b == 0) ? 10 : 11); else pass_cnt++;
            total_cnt++; if (out_data !== exp) $display("FAIL multi_data%0d got %h want %h", b, out_data, exp); else pass_cnt++;
            total_cnt++; if (out_last !== (b == 2)) $display("FAIL multi_last%0d got %b want %b", b, out_last, b == 2); else pass_cnt++;
        end
        tick();
        out_ready = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL multi_idle got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int cyc, bad;
        logic [255:0] key;
        logic [95:0] nonce;
        logic [31:0] ctr;
        logic [511:0] held;
        key = rand_key(); nonce = {$urandom, $urandom, $urandom}; ctr = $urandom_range(0, 32'h7fffffff);
        out_ready = 1'b0;
        send_req(key, nonce, ctr, 8'd2);
        wait_valid(cyc);
        held = out_data;
        total_cnt++; if (out_data !== ref_block(key, nonce, ctr, 20)) $display("FAIL bp_data0 got %h", out_data); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL bp_last0 got %b want 0", out_last); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_key = rand_key(); in_ctr = $urandom;
            tick();
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || out_last !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        $display("backpressure held 20 cycles, %0d disturbed", bad);
        total_cnt++; if (bad != 0) $display("FAIL bp_stall_stable got %0d disturbed cycles want 0", bad); else pass_cnt++;
        out_ready = 1'b1;
        wait_valid(cyc);
        total_cnt++; if (cyc != 11) $display("FAIL bp_gap got %0d want 11", cyc); else pass_cnt++;
        total_cnt++; if (out_data !== ref_block(key, nonce, ctr + 32'd1, 20)) $display("FAIL bp_data1 got %h", out_data); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b1) $display("FAIL bp_last1 got %b want 1", out_last); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_idle got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        int cyc;
        logic [255:0] key;
        logic [95:0] nonce;
        key = rand_key(); nonce = {$urandom, $urandom, $urandom};
        out_ready = 1'b1;
        send_req(key, nonce, 32'hFFFF_FFFF, 8'd2);
        for (int b = 0; b < 2; b++) begin
            wait_valid(cyc);
            $display("wrap block %0d wrapflag=%b last=%b", b, out_ctr_wrap, out_last);
            total_cnt++; if (out_data !== ref_block(key, nonce, 32'hFFFF_FFFF + 32'(b), 20)) $display("FAIL wrap_data%0d got %h", b, out_data); else pass_cnt++;
            total_cnt++; if (out_ctr_wrap !== (b == 1)) $display("FAIL wrap_flag%0d got %b want %b", b, out_ctr_wrap, b == 1); else pass_cnt++;
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_param_sweep();
        int lat [NSW];
        logic [511:0] dat [NSW];
        logic [511:0] exp;
        sw_key = rand_key(); sw_nonce = {$urandom, $urandom, $urandom}; sw_ctr = $urandom;
        for (int i = 0; i < NSW; i++) begin lat[i] = -1; dat[i] = '0; end
        sw_in_valid = 1'b1;
        tick();
        sw_in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            for (int i = 0; i < NSW; i++) begin
                if (sw_out_valid[i] && lat[i] < 0) begin lat[i] = c; dat[i] = sw_out_data[i]; end
            end
        end
        for (int i = 0; i < NSW; i++) begin
            exp = ref_block(sw_key, sw_nonce, sw_ctr, SW_R[i]);
            $display("sweep rounds=%0d dr=%0d latency=%0d", SW_R[i], SW_D[i], lat[i]);
            total_cnt++; if (lat[i] != SW_R[i] / (2 * SW_D[i])) $display("FAIL sweep_latency_r%0d_d%0d got %0d want %0d", SW_R[i], SW_D[i], lat[i], SW_R[i] / (2 * SW_D[i])); else pass_cnt++;
            total_cnt++; if (dat[i] !== exp) $display("FAIL sweep_data_r%0d_d%0d got %h want %h", SW_R[i], SW_D[i], dat[i], exp); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_round();
        int cyc;
        out_ready = 1'b0;
        send_req(RFC_KEY, RFC_NONCE, 32'd1, 8'd2);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        $display("mid-round reset applied");
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_flags got valid=%b ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_no_output got %b want 0", out_valid); else pass_cnt++;
        send_req(RFC_KEY, RFC_NONCE, 32'd1, 8'd1);
        wait_valid(cyc);
        $display("post-reset rfc block latency=%0d", cyc);
        total_cnt++; if (cyc != 10) $display("FAIL midrst_latency got %0d want 10", cyc); else pass_cnt++;
        total_cnt++; if (out_data[511:480] !== 32'he4e7f110 || out_last !== 1'b1) $display("FAIL midrst_block got word0=%h last=%b want e4e7f110/1", out_data[511:480], out_last); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random_requests();
        int cyc, nb;
        logic [255:0] key;
        logic [95:0] nonce;
        logic [31:0] ctr, c;
        for (int r = 0; r < 3; r++) begin
            key = rand_key(); nonce = {$urandom, $urandom, $urandom}; ctr = $urandom;
            nb = $urandom_range(0, 3);
            out_ready = 1'b0;
            send_req(key, nonce, ctr, NBLK_W'(nb));
            for (int b = 0; b < ((nb == 0) ? 1 : nb); b++) begin
                wait_valid(cyc);
                c = ctr + 32'(b);
                $display("random req %0d block %0d ctr=%h last=%b", r, b, c, out_last);
                total_cnt++; if (out_data !== ref_block(key, nonce, c, 20)) $display("FAIL rand_data r%0d b%0d got %h", r, b, out_data); else pass_cnt++;
                total_cnt++; if (out_last !== (b == ((nb == 0) ? 0 : nb - 1))) $display("FAIL rand_last r%0d b%0d got %b", r, b, out_last); else pass_cnt++;
                total_cnt++; if (out_ctr_wrap !== (b > 0 && c == 32'd0)) $display("FAIL rand_wrap r%0d b%0d got %b", r, b, out_ctr_wrap); else pass_cnt++;
                repeat ($urandom_range(0, 3)) tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL rand_idle r%0d got %b want 1", r, in_ready); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_rfc_vector();
        test_multi_block();
        test_backpressure();
        test_counter_wrap();
        test_param_sweep();
        test_reset_mid_round();
        test_random_requests();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
